i2c_scl_gen: RTL and testbench

Parametrised, runtime-programmable successor to the fixed-ratio I2C clock divider. It generates SCL as an open-drain enable from ref_clk. Each SCL period is split into four equal quarter-phases. A one-cycle strobe marks each quarter so the I2C master FSM can time START, STOP and data changes. It also supports slave clock stretching with a timeout, and start/stop gating via en.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_scl_gen_if.sv | 33 +++
 rtl/i2c_sync2.sv | 23 ++
 rtl/i2c_scl_gen.sv | 150 +++++++++++++++
 tb/tb_i2c_scl_gen.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C clock generator and its
// companion blocks (synchronizers, future SDA path).
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOW_A     = 3'd1,
    LOW_B     = 3'd2,
    HIGH_WAIT = 3'd3,
    HIGH_A    = 3'd4,
    HIGH_B    = 3'd5
  } scl_state_t;

  localparam int DIV_Q_MIN   = 2;
  localparam int SYNC_STAGES = 2;

  // Cycles spent in HIGH_WAIT on an unstretched loopback bus: one cycle for
  // the released line to reach the synchronizer plus its two stages.
  localparam int HIGH_WAIT_MIN = 3;

endpackage

// File: rtl/i2c_scl_gen_if.sv
// Control/status bundle between the I2C master FSM (master side) and the
// SCL generator (slave side); scl_in is the raw bus line.
interface i2c_scl_gen_if #(
  parameter int CNT_W = 16
) ();

  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_q;
  logic             scl_in;
  logic             scl_oe;
  logic             i2c_clk;
  logic             tick_fall;
  logic             tick_lmid;
  logic             tick_rise;
  logic             tick_hmid;
  logic             busy;
  logic             stretch;
  logic             stretch_err;

  modport master (
    output en, div_load, div_q, scl_in,
    input  scl_oe, i2c_clk, tick_fall, tick_lmid, tick_rise, tick_hmid,
           busy, stretch, stretch_err
  );

  modport slave (
    input  en, div_load, div_q, scl_in,
    output scl_oe, i2c_clk, tick_fall, tick_lmid, tick_rise, tick_hmid,
           busy, stretch, stretch_err
  );

endinterface

// File: rtl/i2c_sync2.sv
// Generic multi-flop synchronizer for an asynchronous open-drain bus line;
// resets to 1 because an idle I2C line floats high.
module i2c_sync2
  import i2c_pkg::*;
(
  input  logic ref_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of the one before it.
  always_ff @(posedge ref_clk) begin
    if (reset) ff <= '1;
    else       ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// Runtime-programmable I2C SCL generator: four quarter-phases per period,
// per-quarter strobes, slave clock stretching with timeout.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int DIV_Q_DEFAULT = 62,
  parameter int STRETCH_MAX   = 25000
) (
  input  logic          ref_clk,
  input  logic          reset,
  i2c_scl_gen_if.slave  bus
);

  scl_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] div_q_r;
  logic [CNT_W-1:0] div_q_clamped;
  logic             q_end;
  logic             scl_s;

  i2c_sync2 u_scl_sync (
    .ref_clk (ref_clk),
    .reset   (reset),
    .d       (bus.scl_in),
    .q       (scl_s)
  );

  assign div_q_clamped = (bus.div_q < CNT_W'(DIV_Q_MIN)) ? CNT_W'(DIV_Q_MIN) : bus.div_q;
  assign q_end         = (cnt == div_q_r - CNT_W'(1));

  // Outputs are computed from the next state so each strobe lands exactly on
  // the first cycle of its quarter.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      wcnt            <= '0;
      div_q_r         <= CNT_W'(DIV_Q_DEFAULT);
      bus.scl_oe      <= 1'b0;
      bus.i2c_clk     <= 1'b1;
      bus.tick_fall   <= 1'b0;
      bus.tick_lmid   <= 1'b0;
      bus.tick_rise   <= 1'b0;
      bus.tick_hmid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.stretch     <= 1'b0;
      bus.stretch_err <= 1'b0;
    end else begin
      bus.tick_fall   <= 1'b0;
      bus.tick_lmid   <= 1'b0;
      bus.tick_rise   <= 1'b0;
      bus.tick_hmid   <= 1'b0;
      bus.stretch_err <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.div_load) div_q_r <= div_q_clamped;
          if (bus.en) begin
            state         <= LOW_A;
            cnt           <= '0;
            bus.scl_oe    <= 1'b1;
            bus.i2c_clk   <= 1'b0;
            bus.tick_fall <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end

        LOW_A: begin
          if (q_end) begin
            state         <= LOW_B;
            cnt           <= '0;
            bus.tick_lmid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LOW_B: begin
          if (q_end) begin
            state       <= HIGH_WAIT;
            cnt         <= '0;
            wcnt        <= '0;
            bus.scl_oe  <= 1'b0;
            bus.i2c_clk <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HIGH_WAIT: begin
          if (scl_s) begin
            state         <= HIGH_A;
            cnt           <= '0;
            bus.tick_rise <= 1'b1;
            bus.stretch   <= 1'b0;
          end else if (wcnt == CNT_W'(STRETCH_MAX - 1)) begin
            state           <= IDLE;
            bus.stretch     <= 1'b0;
            bus.stretch_err <= 1'b1;
            bus.busy        <= 1'b0;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
            // The cycle about to start has wcnt >= 3: the loopback delay has
            // elapsed, so a low line now means a slave is stretching.
            if (wcnt >= CNT_W'(HIGH_WAIT_MIN - 1)) bus.stretch <= 1'b1;
          end
        end

        HIGH_A: begin
          if (q_end) begin
            state         <= HIGH_B;
            cnt           <= '0;
            bus.tick_hmid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HIGH_B: begin
          if (q_end) begin
            cnt <= '0;
            if (bus.en) begin
              state         <= LOW_A;
              bus.scl_oe    <= 1'b1;
              bus.i2c_clk   <= 1'b0;
              bus.tick_fall <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= '0;
          bus.scl_oe  <= 1'b0;
          bus.i2c_clk <= 1'b1;
          bus.busy    <= 1'b0;
          bus.stretch <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: loopback bus with an injectable slave hold,
// tick timing measured in ref_clk cycles against hand-derived values.
module tb_i2c_scl_gen;
  import i2c_pkg::*;

  localparam int CNT_W   = 16;
  localparam int DEF_Q   = 62;
  localparam int STR_MAX = 50;

  logic ref_clk = 1'b0;
  logic reset   = 1'b1;
  logic hold    = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  i2c_scl_gen_if #(.CNT_W(CNT_W)) bus ();

  i2c_scl_gen #(
    .CNT_W         (CNT_W),
    .DIV_Q_DEFAULT (DEF_Q),
    .STRETCH_MAX   (STR_MAX)
  ) dut (
    .ref_clk (ref_clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Open-drain loopback: line is low if the master drives or the slave holds.
  assign bus.scl_in = bus.i2c_clk & ~hold;

  always #5 ref_clk = ~ref_clk;
  always @(posedge ref_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // which: 0 fall, 1 lmid, 2 rise, 3 hmid, 4 stretch_err
  task automatic wait_tick(input int which, input int budget, output int when);
    logic hit;
    hit  = 1'b0;
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge ref_clk);
      case (which)
        0:       hit = bus.tick_fall;
        1:       hit = bus.tick_lmid;
        2:       hit = bus.tick_rise;
        3:       hit = bus.tick_hmid;
        default: hit = bus.stretch_err;
      endcase
      if (hit) begin
        when = cyc;
        break;
      end
    end
    if (!hit) check($sformatf("wait_tick_%0d_timeout", which), 32'(hit), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge ref_clk);
      if (!bus.busy) break;
    end
    if (i == budget) check("wait_idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_scl_high(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge ref_clk);
      if (bus.i2c_clk) break;
    end
    if (i == budget) check("wait_scl_high_timeout", 32'(bus.i2c_clk), 32'd1);
  endtask

  // Call on the negedge where tick_fall is seen; returns on the next one.
  task automatic meas_period(output int period, output int low);
    logic done;
    done   = 1'b0;
    low    = bus.i2c_clk ? 0 : 1;
    period = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ref_clk);
      period++;
      if (bus.tick_fall) begin
        done = 1'b1;
        break;
      end
      if (!bus.i2c_clk) low++;
    end
    if (!done) check("meas_period_timeout", 32'(done), 32'd1);
  endtask

  task automatic load_q(input int q);
    bus.div_q    = CNT_W'(q);
    bus.div_load = 1'b1;
    @(negedge ref_clk);
    bus.div_load = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, t3, t4, th, te, c0, per, low, nh, nf;

    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_q    = '0;

    // Reset state
    repeat (5) @(posedge ref_clk);
    @(negedge ref_clk);
    check("rst_scl_oe",  32'(bus.scl_oe),  32'd0);
    check("rst_i2c_clk", 32'(bus.i2c_clk), 32'd1);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_ticks",   32'({bus.tick_fall, bus.tick_lmid, bus.tick_rise, bus.tick_hmid}), 32'd0);
    reset = 1'b0;
    @(negedge ref_clk);

    // Default quarter: 4*62+3 = 251, low 124
    c0 = cyc;
    bus.en = 1'b1;
    wait_tick(0, 10, t0);
    check("def_first_fall_latency", 32'(t0 - c0), 32'd1);
    meas_period(per, low);
    check("def_period", 32'(per), 32'(4 * DEF_Q + HIGH_WAIT_MIN));
    check("def_low",    32'(low), 32'd124);
    bus.en = 1'b0;
    wait_idle(400);

    // Programmed quarter 4: 4/7/4/4 spacing, period 19
    load_q(4);
    bus.en = 1'b1;
    wait_tick(0, 10, t0);
    wait_tick(1, 20, t1);
    wait_tick(2, 20, t2);
    wait_tick(3, 20, t3);
    wait_tick(0, 20, t4);
    check("q4_fall_to_lmid", 32'(t1 - t0), 32'd4);
    check("q4_lmid_to_rise", 32'(t2 - t1), 32'd7);
    check("q4_rise_to_hmid", 32'(t3 - t2), 32'd4);
    check("q4_hmid_to_fall", 32'(t4 - t3), 32'd4);
    check("q4_period",       32'(t4 - t0), 32'd19);
    bus.en = 1'b0;
    wait_idle(100);

    // Clamp 0 -> 2 (loaded together with en), then lockout while busy
    bus.div_q    = '0;
    bus.div_load = 1'b1;
    bus.en       = 1'b1;
    wait_tick(0, 10, t0);
    bus.div_load = 1'b0;
    meas_period(per, low);
    check("clamp_period", 32'(per), 32'd11);
    load_q(10);
    check("lockout_busy", 32'(bus.busy), 32'd1);
    wait_tick(0, 40, t0);
    meas_period(per, low);
    check("lockout_period", 32'(per), 32'd11);
    bus.en = 1'b0;
    wait_idle(100);

    // Stretch: slave holds SCL 20 cycles beyond release
    load_q(4);
    hold   = 1'b1;
    bus.en = 1'b1;
    wait_tick(0, 10, t0);
    wait_tick(1, 20, t1);
    wait_scl_high(20);
    repeat (2) @(negedge ref_clk);
    check("stretch_hw_cycle2", 32'(bus.stretch), 32'd0);
    @(negedge ref_clk);
    check("stretch_hw_cycle3", 32'(bus.stretch), 32'd1);
    repeat (17) @(negedge ref_clk);
    hold = 1'b0;
    wait_tick(2, 40, t2);
    check("stretch_rise_delay", 32'(t2 - t1), 32'(4 + HIGH_WAIT_MIN + 20));
    check("stretch_clear_at_rise", 32'(bus.stretch), 32'd0);
    wait_tick(0, 20, t3);
    meas_period(per, low);
    check("stretch_resume_period", 32'(per), 32'd19);
    bus.en = 1'b0;
    wait_idle(100);

    // Timeout: line stuck low
    hold   = 1'b1;
    bus.en = 1'b1;
    wait_tick(1, 20, t1);
    wait_scl_high(20);
    th     = cyc;
    bus.en = 1'b0;
    wait_tick(4, 100, te);
    check("timeout_delay",  32'(te - th), 32'(STR_MAX));
    check("timeout_busy",   32'(bus.busy),   32'd0);
    check("timeout_scl_oe", 32'(bus.scl_oe), 32'd0);
    @(negedge ref_clk);
    check("timeout_err_one_cycle", 32'(bus.stretch_err), 32'd0);
    hold = 1'b0;
    repeat (3) @(negedge ref_clk);

    // Stop: en drops in LOW_A, period completes with exactly one hmid
    bus.en = 1'b1;
    wait_tick(0, 10, t0);
    bus.en = 1'b0;
    nh = 0;
    nf = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ref_clk);
      if (bus.tick_hmid) nh++;
      if (bus.tick_fall) nf++;
      if (!bus.busy) break;
    end
    check("stop_hmid_count",  32'(nh), 32'd1);
    check("stop_fall_count",  32'(nf), 32'd0);
    check("stop_busy",        32'(bus.busy),    32'd0);
    check("stop_scl_high",    32'(bus.i2c_clk), 32'd1);

    // Reset in LOW_B
    bus.en = 1'b1;
    wait_tick(1, 20, t1);
    reset = 1'b1;
    @(negedge ref_clk);
    check("rst_lowb_scl_oe",  32'(bus.scl_oe),  32'd0);
    check("rst_lowb_i2c_clk", 32'(bus.i2c_clk), 32'd1);
    check("rst_lowb_busy",    32'(bus.busy),    32'd0);
    check("rst_lowb_ticks",   32'({bus.tick_fall, bus.tick_lmid, bus.tick_rise, bus.tick_hmid}), 32'd0);
    check("rst_lowb_stretch", 32'({bus.stretch, bus.stretch_err}), 32'd0);
    reset = 1'b0;
    wait_tick(0, 10, t0);
    meas_period(per, low);
    check("rst_default_restored", 32'(per), 32'(4 * DEF_Q + HIGH_WAIT_MIN));
    bus.en = 1'b0;
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
